tap_unloader: RTL and testbench

TAP_UNLOADER -- requirements
Module: tap_unloader

---
 rtl/tap_unloader_if.sv | 20 ++
 rtl/tap_unloader.sv | 62 ++++++
 tb/tb_tap_unloader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tap_unloader_if.sv
// tap_unloader_if: parallel tap inputs, capture request and serial word stream of the tap unloader
interface tap_unloader_if #(parameter int DW = 14);
    logic [DW-1:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
    logic          load;
    logic          dout_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic [3:0]    dout_index;
    logic          busy;
    logic [7:0]    drop_cnt;
    modport master (
        output x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, load, dout_ready,
        input  dout, dout_valid, dout_last, dout_index, busy, drop_cnt
    );
    modport slave (
        input  x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, load, dout_ready,
        output dout, dout_valid, dout_last, dout_index, busy, drop_cnt
    );
endinterface

// File: rtl/tap_unloader.sv
// tap_unloader: snapshots parallel taps on load and streams them oldest-first with valid/ready
module tap_unloader #(
    parameter int DW    = 14,
    parameter int NTAPS = 10
) (
    input logic           clk,
    input logic           reset,
    tap_unloader_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t        state;
    logic [DW-1:0] xin  [0:9];
    logic [DW-1:0] snap [0:NTAPS-1];
    logic [DW-1:0] dout;
    logic [3:0]    idx;
    logic          last;
    logic [7:0]    drops;
    assign xin = '{bus.x0, bus.x1, bus.x2, bus.x3, bus.x4, bus.x5, bus.x6, bus.x7, bus.x8, bus.x9};
    assign bus.dout       = dout;
    assign bus.dout_index = idx;
    assign bus.dout_last  = last;
    assign bus.dout_valid = state == SEND;
    assign bus.busy       = state == SEND;
    assign bus.drop_cnt   = drops;
    // Capture/stream FSM: the word on dout is always the snapshot entry at idx, zeroed while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            for (int i = 0; i < NTAPS; i++) snap[i] <= '0;
            dout  <= '0;
            idx   <= '0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.load) begin
                    for (int i = 0; i < NTAPS; i++) snap[i] <= xin[i];
                    state <= SEND;
                    dout  <= xin[NTAPS-1];
                    idx   <= 4'(NTAPS - 1);
                    last  <= NTAPS == 1;
                end
                SEND: if (bus.dout_ready) begin
                    if (idx == 4'd0) begin
                        state <= IDLE;
                        dout  <= '0;
                        last  <= 1'b0;
                    end else begin
                        dout <= snap[idx - 4'd1];
                        idx  <= idx - 4'd1;
                        last <= idx == 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Loads arriving mid-burst, including the final-transfer cycle, are dropped and counted up to 255
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drops <= '0;
        else if (state == SEND && bus.load && drops != 8'hFF) drops <= drops + 8'd1;
    end
endmodule

// File: tb/tb_tap_unloader.sv
// tb_tap_unloader: table-driven burst vectors plus hand-written reset and saturation sequences
module tb_tap_unloader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    tap_unloader_if #(.DW(14)) bus ();
    tap_unloader #(.DW(14), .NTAPS(10)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        load;
        logic        ready;
        logic        hi;
        logic [13:0] dout;
        logic [3:0]  idx;
        logic        last;
        logic        valid;
        logic        busy;
        logic [7:0]  drop;
    } vec_t;
    vec_t vecs[$];
    task automatic add(input logic load, input logic ready, input logic hi, input logic [13:0] dout,
                       input logic [3:0] idx, input logic last, input logic valid, input logic [7:0] drop);
        vec_t v;
        v.load = load; v.ready = ready; v.hi = hi; v.dout = dout; v.idx = idx;
        v.last = last; v.valid = valid; v.busy = valid; v.drop = drop;
        vecs.push_back(v);
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic set_x(input logic hi);
        bus.x0 = hi ? 14'h3FFF : 14'd100; bus.x1 = hi ? 14'h3FFF : 14'd101;
        bus.x2 = hi ? 14'h3FFF : 14'd102; bus.x3 = hi ? 14'h3FFF : 14'd103;
        bus.x4 = hi ? 14'h3FFF : 14'd104; bus.x5 = hi ? 14'h3FFF : 14'd105;
        bus.x6 = hi ? 14'h3FFF : 14'd106; bus.x7 = hi ? 14'h3FFF : 14'd107;
        bus.x8 = hi ? 14'h3FFF : 14'd108; bus.x9 = hi ? 14'h3FFF : 14'd109;
    endtask
    task automatic check_out(input string tag, input logic [13:0] dout, input logic [3:0] idx,
                             input logic last, input logic valid, input logic [7:0] drop);
        check({tag, ".dout"}, 32'(bus.dout), 32'(dout));
        check({tag, ".index"}, 32'(bus.dout_index), 32'(idx));
        check({tag, ".last"}, 32'(bus.dout_last), 32'(last));
        check({tag, ".valid"}, 32'(bus.dout_valid), 32'(valid));
        check({tag, ".busy"}, 32'(bus.busy), 32'(valid));
        check({tag, ".drop"}, 32'(bus.drop_cnt), 32'(drop));
    endtask
    initial begin
        // basic burst with ready tied high
        add(1, 1, 0, 109, 9, 0, 1, 0);
        for (int i = 8; i >= 0; i--) add(0, 1, 0, 14'(100 + i), 4'(i), i == 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // backpressure: three stalled edges while 105 is presented
        add(1, 1, 0, 109, 9, 0, 1, 0);
        for (int i = 8; i >= 5; i--) add(0, 1, 0, 14'(100 + i), 4'(i), 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 105, 5, 0, 1, 0);
        for (int i = 4; i >= 0; i--) add(0, 1, 0, 14'(100 + i), 4'(i), i == 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // rejected loads mid-burst and on the final transfer
        add(1, 1, 0, 109, 9, 0, 1, 0);
        add(0, 1, 0, 108, 8, 0, 1, 0);
        add(1, 1, 0, 107, 7, 0, 1, 1);
        for (int i = 6; i >= 0; i--) add(0, 1, 0, 14'(100 + i), 4'(i), i == 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0, 0, 0, 2);
        // inputs change after capture; then a burst capturing all-ones
        add(1, 1, 0, 109, 9, 0, 1, 2);
        for (int i = 8; i >= 0; i--) add(0, 1, 1, 14'(100 + i), 4'(i), i == 0, 1, 2);
        add(0, 1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 14'h3FFF, 9, 0, 1, 2);
        for (int i = 8; i >= 0; i--) add(0, 1, 0, 14'h3FFF, 4'(i), i == 0, 1, 2);
        add(0, 1, 0, 0, 0, 0, 0, 2);
        bus.load = 1'b0;
        bus.dout_ready = 1'b0;
        set_x(1'b0);
        #3;
        check_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        foreach (vecs[n]) begin
            bus.load = vecs[n].load;
            bus.dout_ready = vecs[n].ready;
            set_x(vecs[n].hi);
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("vec%0d", n), vecs[n].dout, vecs[n].idx, vecs[n].last, vecs[n].valid, vecs[n].drop);
        end
        // asynchronous reset in the middle of index 4, then a fresh full burst
        bus.load = 1'b1;
        bus.dout_ready = 1'b1;
        set_x(1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_out("pre_rst", 104, 4, 0, 1, 2);
        #2 reset = 1'b1;
        #1 check_out("mid_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_out("post_rst", 0, 0, 0, 0, 0);
        bus.load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        check_out("rst_burst9", 109, 9, 0, 1, 0);
        for (int i = 8; i >= 0; i--) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("rst_burst%0d", i), 14'(100 + i), 4'(i), i == 0, 1, 0);
        end
        @(posedge clk);
        @(negedge clk);
        check_out("rst_done", 0, 0, 0, 0, 0);
        // drop counter saturation with the burst stalled
        bus.load = 1'b1;
        bus.dout_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_out("sat_start", 109, 9, 0, 1, 0);
        repeat (254) @(posedge clk);
        @(negedge clk);
        check_out("sat_254", 109, 9, 0, 1, 254);
        @(posedge clk);
        @(negedge clk);
        check_out("sat_255", 109, 9, 0, 1, 255);
        repeat (45) @(posedge clk);
        @(negedge clk);
        check_out("sat_300", 109, 9, 0, 1, 255);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
